// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART-to-RAM program loader.
package uart_loader_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    localparam int BYTES_PER_WORD       = 4;
    localparam int BYTE_IDX_W           = $clog2(BYTES_PER_WORD);
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_ram_loader_if.sv
// RAM second write port (addr2/dataIn2/wEn2) driven by the loader.
interface uart_ram_loader_if #(parameter int ADDR_WIDTH = 12);

    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [31:0]           write_data;

    modport master (output write_en, write_addr, write_data);
    modport slave  (input  write_en, write_addr, write_data);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser plus mid-bit sampling FSM.
// rx_valid/frame_err are single-cycle strobes on the stop-bit sample edge.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_ff;
    logic             rx_line;
    rx_state_e        state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             bit_end;

    assign rx_line = sync_ff[1];
    assign bit_end = (cnt == BIT_LAST);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (!rx_line) state_n = START;
            // A line that is back high at mid-start-bit is treated as noise.
            START: if (cnt == HALF_LAST) state_n = rx_line ? IDLE : DATA;
            DATA:  if (bit_end && bit_idx == 3'd7) state_n = STOP;
            STOP:  if (bit_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign rx_valid  = (state == STOP) && bit_end && rx_line;
    assign frame_err = (state == STOP) && bit_end && !rx_line;
    assign rx_byte   = rx_shift;
    assign rx_busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff  <= 2'b11;
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            sync_ff <= {sync_ff[0], serial_in};
            state   <= state_n;
            if (state == IDLE || state_n != state || (state == DATA && bit_end))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == IDLE)
                bit_idx <= '0;
            if (state == DATA && bit_end) begin
                rx_shift <= {rx_line, rx_shift[7:1]};
                bit_idx  <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/uart_ram_loader.sv
// Serial program loader: packs UART bytes little-endian into 32-bit RAM writes.
// Define UART_LOADER_TIMEOUT_EN to drop a partial word after TIMEOUT_CLKS idle cycles.
module uart_ram_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_WIDTH   = 12,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  set_addr,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    uart_ram_loader_if.master     ram,
    output logic [7:0]            last_byte,
    output logic                  byte_valid,
    output logic                  err,
    output logic                  busy
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    if (CLKS_PER_BIT < 4 || TIMEOUT_CLKS < 1) begin : g_param_chk
        $error("uart_ram_loader: CLKS_PER_BIT must be >= 4 and TIMEOUT_CLKS >= 1");
    end

    logic [7:0]            rx_byte;
    logic                  rx_valid, frame_err, rx_busy;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [23:0]           word_lo;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  we_q;
    logic [31:0]           wdata_q;
    logic                  drop_partial;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

`ifdef UART_LOADER_TIMEOUT_EN
    localparam int            TO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
    logic [TO_W-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (reset || rx_busy || byte_idx == '0 || set_addr)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign drop_partial = (idle_cnt == TO_LAST) && !rx_busy && (byte_idx != '0);
`else
    assign drop_partial = 1'b0;
`endif

    assign ram.write_en   = we_q;
    assign ram.write_addr = ptr;
    assign ram.write_data = wdata_q;
    assign busy           = rx_busy || (byte_idx != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx   <= '0;
            word_lo    <= '0;
            ptr        <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            last_byte  <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            we_q       <= 1'b0;
            byte_valid <= rx_valid;
            if (rx_valid)  last_byte <= rx_byte;
            if (frame_err) err       <= 1'b1;
            // set_addr outranks both the pointer bump and a completing byte.
            if (set_addr) begin
                ptr      <= start_addr;
                byte_idx <= '0;
            end else begin
                if (we_q) ptr <= ptr + 1'b1;
                if (rx_valid) begin
                    if (byte_idx == LAST_IDX) begin
                        we_q     <= 1'b1;
                        wdata_q  <= {rx_byte, word_lo};
                        byte_idx <= '0;
                    end else begin
                        word_lo[8*byte_idx +: 8] <= rx_byte;
                        byte_idx <= byte_idx + 1'b1;
                    end
                end else if (drop_partial) begin
                    byte_idx <= '0;
                end
            end
        end
    end

endmodule
